ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched operands and the decoded mul/div operation, and computes into architectural HI/LO registers. It raises busy/stall to the hazard unit so ID/EX and earlier stages hold while an operation is in flight. A pipeline flush aborts an in-flight operation.

---
 rtl/ex_muldiv_if.sv | 39 +++
 rtl/ex_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: issue/result bundle between the EX-stage control and the
// iterative multiply/divide unit.
//   master : ID/EX + hazard side (drives start/op/operands/flush/hilo_wr)
//   slave  : ex_muldiv (drives hi/lo/busy/done/stall)
// Signals
//   start    issue request (ID/EX op is mul/div, not a bubble)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    multiplicand / dividend
//   src_b    multiplier / divisor
//   flush    kill in-flight operation
//   hilo_wr  bit1 MTHI, bit0 MTLO; wr_data supplies the value
//   hi, lo   architectural HI/LO
//   busy     unit not idle
//   done     one-cycle pulse, HI/LO already hold the result
//   stall    hold request to the hazard unit (== busy)
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic [1:0]      hilo_wr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall;

  modport master (
    output start, op, src_a, src_b, flush, hilo_wr, wr_data,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hilo_wr, wr_data,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/divide unit with HI/LO registers.
// Sign-magnitude datapath: operands are latched as magnitudes, a 32-step
// shift-add multiply or restoring divide runs, then a single FIX cycle
// applies the sign and writes HI/LO.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : ex_muldiv_if.slave (issue, flush, MTHI/MTLO, HI/LO, busy/done/stall)
// Build option
//   MULDIV_FAST_MUL_EN : MULT/MULTU use a combinational 32x32 multiplier and
//                        go IDLE->FIX directly (2-edge latency). Divide is
//                        unchanged. Undefined: everything iterates.
module ex_muldiv #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] DZ_QUOT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  localparam int             CW   = $clog2(XLEN);
  localparam logic [CW-1:0]  LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // mul: {partial product, multiplier}; div: low half holds dividend/quotient
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]       a_org_q, a_org_d;   // dividend as given, for div-by-zero
  logic [XLEN-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                  is_div_q, is_div_d;
  logic                  negq_q, negq_d, negr_q, negr_d;
  logic                  dz_q, dz_d;
  logic                  done_q, done_d;
  logic                  busy;

  // ---- issue-side operand conditioning ----
  logic                  issue, sgn, a_neg, b_neg, fast_issue;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic [2*XLEN-1:0]     fast_prod;

  assign issue = (state_q == S_IDLE) & bus.start & ~bus.flush;
  assign sgn   = ~bus.op[0];
  assign a_neg = sgn & bus.src_a[XLEN-1];
  assign b_neg = sgn & bus.src_b[XLEN-1];
  // 0x8000_0000 negates to itself, which reads correctly as unsigned 2^31
  assign a_mag = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag = b_neg ? -bus.src_b : bus.src_b;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_issue = issue & ~bus.op[1];
  assign fast_prod  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
  assign fast_issue = 1'b0;
  assign fast_prod  = '0;
`endif

  // ---- per-step arithmetic ----
  logic [XLEN:0]         mul_sum;
  logic [XLEN:0]         div_part;   // 33-bit partial remainder after shift-in
  logic [XLEN-1:0]       div_sub;
  logic                  div_ge;
  logic [2*XLEN-1:0]     prod_fix;
  logic [XLEN-1:0]       quo_fix, rem_fix;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
  assign div_part = {rem_q, acc_q[XLEN-1]};
  assign div_ge   = div_part >= {1'b0, mcand_q};
  // remainder after a successful subtract is below the divisor, so it fits
  assign div_sub  = XLEN'(div_part - {1'b0, mcand_q});
  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign quo_fix  = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = negr_q ? -rem_q : rem_q;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (issue) state_d = fast_issue ? S_FIX : S_RUN;
      S_RUN:  if (bus.flush)          state_d = S_IDLE;
              else if (cnt_q == LAST) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // ---- datapath next state ----
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    mcand_d  = mcand_q;
    a_org_d  = a_org_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // MTHI/MTLO land even when an op issues this cycle; the result
        // overwrites them later.
        if (!bus.flush) begin
          if (bus.hilo_wr[1]) hi_d = bus.wr_data;
          if (bus.hilo_wr[0]) lo_d = bus.wr_data;
        end
        if (issue) begin
          cnt_d    = '0;
          mcand_d  = b_mag;
          a_org_d  = bus.src_a;
          is_div_d = bus.op[1];
          negq_d   = a_neg ^ b_neg;
          negr_d   = a_neg;
          dz_d     = (bus.src_b == '0);
          rem_d    = '0;
          acc_d    = fast_issue ? fast_prod : {{XLEN{1'b0}}, a_mag};
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          rem_d             = div_ge ? div_sub : div_part[XLEN-1:0];
          acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
      end
      S_FIX: begin
        if (!bus.flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end else if (dz_q) begin
            hi_d = a_org_q;
            lo_d = DZ_QUOT;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      mcand_q  <= '0;
      a_org_q  <= '0;
      is_div_q <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      mcand_q  <= mcand_d;
      a_org_q  <= a_org_d;
      is_div_q <= is_div_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy;
  assign bus.stall = busy;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus();
  ex_muldiv #(.XLEN(32), .DZ_QUOT(32'hFFFF_FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  // Reference: plain 64-bit arithmetic, SV '/' and '%' truncate toward zero.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: p = '0;
    endcase
    h = p[63:32];
    l = p[31:0];
    if (op[1]) begin
      if (b == 32'd0) begin
        h = a; l = 32'hFFFF_FFFF;
      end else begin
        if (op[0]) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
        q = sa / sb;
        r = sa % sb;
        h = r[31:0];
        l = q[31:0];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one op and wait (bounded) for done. lat counts edges from the
  // start edge (inclusive) to the edge after which done is seen.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, b,
                       output int lat, output logic [31:0] h, output logic [31:0] l,
                       output logic busy0, output bit stall_ok);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0;
    busy0 = bus.busy;
    lat = 1;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      tick();
      lat++;
    end
    h = bus.hi;
    l = bus.lo;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [8]  = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] as  [8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'd100, 32'h8000_0000, 32'd5, 32'd0};
    logic [31:0] bs  [8]  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                              32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] eh  [8]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF,
                              32'd2, 32'd0, 32'd5, 32'd0};
    logic [31:0] el  [8]  = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd0, 32'hFFFF_FFFD,
                              32'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    int lat, elat;
    logic [31:0] h, l;
    logic b0;
    bit sok;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], lat, h, l, b0, sok);
      elat = ops[i][1] ? DIV_LAT : MUL_LAT;
      n_tests++; if (h !== eh[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, h, eh[i]); end
      n_tests++; if (l !== el[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, l, el[i]); end
      n_tests++; if (lat !== elat) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, elat); end
      n_tests++; if (!sok || b0 !== 1'b1) begin n_fail++; $display("FAIL dir%0d_stall: got busy0=%b stall_ok=%0d want 1/1", i, b0, sok); end
      tick();
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, bus.done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, h, l, mh, ml;
    int lat;
    logic b0;
    bit sok;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(op, a, b, mh, ml);
      issue(op, a, b, lat, h, l, b0, sok);
      n_tests++; if (h !== mh || l !== ml) begin
        n_fail++; $display("FAIL rand%0d op%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h", i, op, a, b, h, l, mh, ml);
      end
      n_tests++; if (lat !== (op[1] ? DIV_LAT : MUL_LAT)) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, op[1] ? DIV_LAT : MUL_LAT);
      end
    end
  endtask

  task automatic test_hilo_wr();
    int n;
    bus.hilo_wr = 2'b11; bus.wr_data = 32'h1234; tick();
    bus.hilo_wr = 2'b00;
    n_tests++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h1234) begin n_fail++; $display("FAIL mthilo_both: got %h/%h want 1234/1234", bus.hi, bus.lo); end
    bus.hilo_wr = 2'b01; bus.wr_data = 32'h77; tick();
    bus.hilo_wr = 2'b00;
    n_tests++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h77) begin n_fail++; $display("FAIL mtlo_only: got %h/%h want 1234/77", bus.hi, bus.lo); end
    bus.hilo_wr = 2'b10; bus.wr_data = 32'h99; bus.flush = 1'b1; tick();
    bus.hilo_wr = 2'b00; bus.flush = 1'b0;
    n_tests++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_flushed: got %h want 1234", bus.hi); end
    // start + MTHI/MTLO together: write lands, op still issues
    bus.start = 1'b1; bus.op = 2'd3; bus.src_a = 32'd42; bus.src_b = 32'd6;
    bus.hilo_wr = 2'b11; bus.wr_data = 32'h55; tick();
    bus.start = 1'b0; bus.hilo_wr = 2'b00;
    n_tests++; if (bus.hi !== 32'h55 || bus.lo !== 32'h55 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL start_with_mthilo: got hi=%h lo=%h busy=%b want 55/55/1", bus.hi, bus.lo, bus.busy);
    end
    tick(); tick();
    bus.hilo_wr = 2'b11; bus.wr_data = 32'hAA; tick();
    bus.hilo_wr = 2'b00;
    n_tests++; if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin n_fail++; $display("FAIL mthilo_busy: got %h/%h want 55/55", bus.hi, bus.lo); end
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
    n_tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd7 || n >= 100) begin
      n_fail++; $display("FAIL result_over_mthilo: got hi=%h lo=%h want 0/7", bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] h, l;
    logic b0;
    bit sok;
    bus.hilo_wr = 2'b10; bus.wr_data = 32'hDEAD_0001; tick();
    bus.hilo_wr = 2'b01; bus.wr_data = 32'hBEEF_0002; tick();
    bus.hilo_wr = 2'b00;
    // flush and start together: nothing issues
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'd2; bus.src_a = 32'd9; bus.src_b = 32'd3; tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_same: got busy=%b want 0", bus.busy); end
    bus.start = 1'b1; bus.op = 2'd2; bus.src_a = 32'd1000; bus.src_b = 32'd3; tick();
    bus.start = 1'b0;
    repeat (9) tick();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_before_flush: got %b want 1", bus.busy); end
    bus.flush = 1'b1; tick();
    bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL flush_abort: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    n_tests++; if (bus.hi !== 32'hDEAD_0001 || bus.lo !== 32'hBEEF_0002) begin
      n_fail++; $display("FAIL flush_hilo_kept: got %h/%h want DEAD0001/BEEF0002", bus.hi, bus.lo);
    end
    issue(2'd1, 32'd3, 32'd4, lat, h, l, b0, sok);
    n_tests++; if (h !== 32'd0 || l !== 32'd12 || lat !== MUL_LAT) begin
      n_fail++; $display("FAIL after_flush_multu: got hi=%h lo=%h lat=%0d want 0/c/%0d", h, l, lat, MUL_LAT);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] h, l;
    logic b0;
    bit sok;
    issue(2'd1, 32'hFFFF_FFFF, 32'h0000_0003, lat, h, l, b0, sok);
    bus.start = 1'b1; bus.op = 2'd0; bus.src_a = 32'd12345; bus.src_b = 32'd678; tick();
    bus.start = 1'b0;
    rst = 1'b0; tick();
    n_tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    rst = 1'b1; tick();
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3] = '{2'd3, 2'd0, 2'd3};
    logic [31:0] as  [3] = '{32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd7, 32'd7, 32'h10};
    logic [31:0] h, l, mh, ml;
    int lat;
    logic b0;
    bit sok;
    // each issue returns in the done cycle, so the next start lands there
    for (int i = 0; i < 3; i++) begin
      model(ops[i], as[i], bs[i], mh, ml);
      issue(ops[i], as[i], bs[i], lat, h, l, b0, sok);
      n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_accept: got busy=%b want 1", i, b0); end
      n_tests++; if (h !== mh || l !== ml) begin n_fail++; $display("FAIL b2b%0d_result: got %h/%h want %h/%h", i, h, l, mh, ml); end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hilo_wr = 2'b00; bus.wr_data = '0;
    test_reset();
    test_directed();
    test_random();
    test_hilo_wr();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
